// File: rtl/vram_line_fetcher.sv
// vram_line_fetcher: streams VRAM read bursts to a pixel consumer through a credit-limited FWFT FIFO
// Ports: clk, reset_n_i (async, active-low); cmd_* command handshake (start address, word count, 0 = no-op);
//        abort_i cancels and flushes; vram_* read-only VRAM initiator, a read issues on vram_sel_o && gnt_i;
//        px_* first-word-fall-through pixel stream; busy_o command in progress; done_o completion pulse.
module vram_line_fetcher #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_addr_i,
    input  logic [15:0] cmd_len_i,
    input  logic        abort_i,
    output logic        vram_sel_o,
    output logic        vram_wr_en_o,
    output logic [3:0]  vram_wr_mask_o,
    output logic [15:0] vram_address_o,
    input  logic [15:0] vram_data_i,
    input  logic        gnt_i,
    output logic        px_valid_o,
    input  logic        px_ready_i,
    output logic [15:0] px_data_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_LAST} state_t;

    state_t        state_q, state_d;
    logic [15:0]   addr_q, rem_q;
    logic          inflight_q, done_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic [15:0]   mem [FIFO_DEPTH];
    logic          accept, issue, push, pop, credit_ok;

    // a read in flight already owns one FIFO slot
    assign credit_ok      = count_q < (inflight_q ? CW'(FIFO_DEPTH - 1) : CW'(FIFO_DEPTH));
    assign cmd_ready_o    = state_q == IDLE && !abort_i;
    assign vram_sel_o     = state_q == FETCH && credit_ok;
    assign accept         = cmd_valid_i && cmd_ready_o;
    assign issue          = vram_sel_o && gnt_i;
    assign push           = inflight_q && !abort_i;
    assign pop            = px_valid_o && px_ready_i && !abort_i;
    assign vram_wr_en_o   = 1'b0;
    assign vram_wr_mask_o = 4'b0000;
    assign vram_address_o = addr_q;
    assign busy_o         = state_q != IDLE;
    assign done_o         = done_q;
    assign px_valid_o     = count_q != '0;
    assign px_data_o      = px_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = abort_i                                      ? IDLE :
                  (accept && cmd_len_i != '0)                  ? FETCH :
                  (state_q == FETCH && issue && rem_q == 16'd1) ? WAIT_LAST :
                  (state_q == WAIT_LAST && inflight_q)         ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
        end else if (abort_i) begin
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            done_q     <= (accept && cmd_len_i == '0) || (state_q == WAIT_LAST && inflight_q);
            addr_q     <= accept ? cmd_addr_i : issue ? addr_q + 16'd1 : addr_q;
            rem_q      <= accept ? cmd_len_i : issue ? rem_q - 16'd1 : rem_q;
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count_q    <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= vram_data_i;
    end
endmodule
